// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: control and pulse bundle of the UART baud generator.
// Configuration macro: BAUD_FRAC_EN adds the 8-bit frac_in signal.
// Ports (master drives the controls, slave is the generator):
//   enable  run request        Select  baud select (7 = div_in register)
//   sync    phase restart      div_wr  load strobe for div_in / frac_in
//   div_in  divisor            frac_in fractional divisor n/256 (BAUD_FRAC_EN)
//   os_tick oversample pulse   tick    mid-bit pulse     locked  in RUN
interface uart_baud_gen_if #(
    parameter int CNT_W = 24
);
    logic             enable;
    logic [2:0]       Select;
    logic             sync;
    logic             div_wr;
    logic [CNT_W-1:0] div_in;
`ifdef BAUD_FRAC_EN
    logic [7:0]       frac_in;
`endif
    logic             os_tick;
    logic             tick;
    logic             locked;
`ifdef BAUD_FRAC_EN
    modport master (output enable, Select, sync, div_wr, div_in, frac_in, input os_tick, tick, locked);
    modport slave (input enable, Select, sync, div_wr, div_in, frac_in, output os_tick, tick, locked);
`else
    modport master (output enable, Select, sync, div_wr, div_in, input os_tick, tick, locked);
    modport slave (input enable, Select, sync, div_wr, div_in, output os_tick, tick, locked);
`endif
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample and mid-bit tick generator for a UART receiver.
// Configuration macro: BAUD_FRAC_EN enables the n/256 fractional divisor.
// Ports:
//   Clk  system clock, rising edge
//   Rst  synchronous active-high reset
//   bus  uart_baud_gen_if.slave: enable, Select, sync, div_wr, div_in,
//        frac_in (BAUD_FRAC_EN) in; os_tick, tick, locked out (registered)
module uart_baud_gen #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 24
) (
    input logic            Clk,
    input logic            Rst,
    uart_baud_gen_if.slave bus
);
    localparam int PH_W = $clog2(OVERSAMPLE);

    typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

    function automatic logic [CNT_W-1:0] rate_div(input longint baud);
        longint d;
        d = (longint'(CLK_HZ) + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE);
        return d < 2 ? CNT_W'(2) : CNT_W'(d);
    endfunction

    // Entry 7 is unused; Select 7 takes div_reg instead.
    localparam logic [CNT_W-1:0] RATE_DIV [8] = '{
        rate_div(300), rate_div(1200), rate_div(2400), rate_div(4800),
        rate_div(9600), rate_div(19200), rate_div(115200), CNT_W'(2)
    };

    state_t           state;
    logic [CNT_W-1:0] os_cnt, div, div_reg, sel_div, term;
    logic [PH_W-1:0]  ph;
    logic             wrap;
    logic             os_tick_q, tick_q, locked_q;
`ifdef BAUD_FRAC_EN
    logic [7:0]       frac_reg, frac_acc;
    logic [8:0]       frac_sum;
    logic             ext;
`endif

    always_comb begin
        sel_div = bus.Select == 3'd7 ? div_reg : RATE_DIV[bus.Select];
`ifdef BAUD_FRAC_EN
        // A carry from the previous wrap stretches this period by one cycle.
        term     = ext ? div : div - CNT_W'(1);
        frac_sum = {1'b0, frac_acc} + {1'b0, frac_reg};
`else
        term     = div - CNT_W'(1);
`endif
        wrap = os_cnt == term;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            os_cnt    <= '0;
            ph        <= '0;
            div       <= CNT_W'(2);
            div_reg   <= CNT_W'(2);
            os_tick_q <= 1'b0;
            tick_q    <= 1'b0;
            locked_q  <= 1'b0;
`ifdef BAUD_FRAC_EN
            frac_reg  <= '0;
            frac_acc  <= '0;
            ext       <= 1'b0;
`endif
        end else begin
            if (bus.div_wr) begin
                div_reg  <= bus.div_in < CNT_W'(2) ? CNT_W'(2) : bus.div_in;
`ifdef BAUD_FRAC_EN
                frac_reg <= bus.frac_in;
`endif
            end
            if (!bus.enable) begin
                state     <= IDLE;
                os_cnt    <= '0;
                ph        <= '0;
                os_tick_q <= 1'b0;
                tick_q    <= 1'b0;
                locked_q  <= 1'b0;
`ifdef BAUD_FRAC_EN
                frac_acc  <= '0;
                ext       <= 1'b0;
`endif
            end else if (state == IDLE || bus.sync) begin
                // Starting at mid-phase puts the first tick half a bit out.
                state     <= ALIGN;
                os_cnt    <= '0;
                ph        <= PH_W'(OVERSAMPLE / 2);
                div       <= sel_div;
                os_tick_q <= 1'b0;
                tick_q    <= 1'b0;
                locked_q  <= 1'b0;
`ifdef BAUD_FRAC_EN
                frac_acc  <= '0;
                ext       <= 1'b0;
`endif
            end else if (wrap) begin
                os_cnt    <= '0;
                ph        <= ph + PH_W'(1);
                div       <= sel_div;
                os_tick_q <= 1'b1;
                tick_q    <= &ph;
                locked_q  <= state == RUN || &ph;
                state     <= &ph ? RUN : state;
`ifdef BAUD_FRAC_EN
                frac_acc  <= frac_sum[7:0];
                ext       <= frac_sum[8];
`endif
            end else begin
                os_cnt    <= os_cnt + CNT_W'(1);
                os_tick_q <= 1'b0;
                tick_q    <= 1'b0;
                locked_q  <= state == RUN;
            end
        end
    end

    assign bus.os_tick = os_tick_q;
    assign bus.tick    = tick_q;
    assign bus.locked  = locked_q;
endmodule
